// File: rtl/rv32_mem_pkg.sv
// rtl/rv32_mem_pkg.sv - shared types and helpers for the data memory responder
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    COMMIT,
    RESP
  } resp_state_e;

  typedef logic [3:0] byte_en_t;

  localparam int WAIT_CNT_W = 4;

  // Take each lane from new_word where its enable is set, otherwise keep old_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input byte_en_t    be);
    logic [31:0] merged;
    for (int k = 0; k < 4; k++) begin
      merged[8*k +: 8] = be[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/rv32_byte_en_ram.sv
// rtl/rv32_byte_en_ram.sv - single-port word RAM with byte write enables, read-first output
module rv32_byte_en_ram
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  byte_en_t          we_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  // Registered read returns the pre-write contents; enabled lanes are updated in the same edge.
  always_ff @(posedge clk_i) begin
    rdata_o <= mem[addr_i];
    for (int k = 0; k < 4; k++) begin
      if (we_i[k]) begin
        mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/rv32_data_memory_responder.sv
// rtl/rv32_data_memory_responder.sv - one-outstanding load/store responder with wait states
module rv32_data_memory_responder
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_write_enable_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o
);

  localparam int ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_STATES);

  resp_state_e           state, state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic [29:0]           word_idx;
  byte_en_t              we_q;
  logic [31:0]           wdata_q;
  logic                  accept;
  logic                  in_range;
  logic [ADDR_W-1:0]     ram_addr;
  byte_en_t              ram_we;
  logic [31:0]           ram_rdata;
  logic                  addr_lsb_unused;

  // Lane placement is done by the requester, so the byte offset carries no information.
  assign addr_lsb_unused = ^req_addr_i[1:0];

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);
  assign accept      = req_valid_i && (state == IDLE);

  // Full 30-bit index compare: indices past the RAM never alias onto a low word.
  assign in_range = {2'b00, word_idx} < 32'(DEPTH_WORDS);

  // The RAM reads every cycle; addressing it from the live request in IDLE and from the
  // captured index afterwards means the old word is on ram_rdata by the time COMMIT runs.
  assign ram_addr = (state == IDLE) ? req_addr_i[ADDR_W+1:2] : word_idx[ADDR_W-1:0];
  assign ram_we   = ((state == COMMIT) && in_range) ? we_q : '0;

  rv32_byte_en_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  // Capture the request on acceptance; a discarded capture is harmless since state gates use.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      word_idx <= req_addr_i[31:2];
      we_q     <= req_write_enable_i;
      wdata_q  <= req_wdata_i;
    end
  end

  // State and wait-counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state logic: accept, wait WAIT_STATES cycles, commit once, hold response until taken.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          wait_cnt_next = '0;
          state_next    = (WAIT_STATES > 0) ? WAIT : COMMIT;
        end
      end
      WAIT: begin
        if (wait_cnt + 1'b1 == WAIT_LAST) begin
          wait_cnt_next = '0;
          state_next    = COMMIT;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      COMMIT: state_next = RESP;
      RESP: begin
        if (rsp_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Response payload is loaded only in COMMIT, so backpressure in RESP keeps it stable.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
    end else if (state == COMMIT) begin
      if (in_range) begin
        rsp_rdata_o <= merge_lanes(ram_rdata, wdata_q, we_q);
        rsp_error_o <= 1'b0;
      end else begin
        rsp_rdata_o <= '0;
        rsp_error_o <= 1'b1;
      end
    end else if ((state == RESP) && rsp_ready_i) begin
      rsp_error_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32_data_memory_responder.sv
// tb/tb_rv32_data_memory_responder.sv - directed self-checking bench for the data memory responder
module tb_rv32_data_memory_responder;

  logic        clk;
  logic        rst_n;

  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_error;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_we;

  logic        z_req_valid, z_req_ready, z_rsp_valid, z_rsp_ready, z_rsp_error;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [3:0]  z_req_we;

  int n_checks = 0;
  int n_fail   = 0;

  rv32_data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_addr_i         (req_addr),
    .req_write_enable_i (req_we),
    .req_wdata_i        (req_wdata),
    .rsp_valid_o        (rsp_valid),
    .rsp_ready_i        (rsp_ready),
    .rsp_rdata_o        (rsp_rdata),
    .rsp_error_o        (rsp_error)
  );

  rv32_data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_z (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .req_valid_i        (z_req_valid),
    .req_ready_o        (z_req_ready),
    .req_addr_i         (z_req_addr),
    .req_write_enable_i (z_req_we),
    .req_wdata_i        (z_req_wdata),
    .rsp_valid_o        (z_rsp_valid),
    .rsp_ready_i        (z_rsp_ready),
    .rsp_rdata_o        (z_rsp_rdata),
    .rsp_error_o        (z_rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request on the WAIT_STATES=1 instance. lat is the edge, counted from the acceptance
  // edge, at which the requester first samples rsp_valid high. hold = cycles of rsp_ready=0.
  task automatic txn(input string tag, input logic [31:0] a, input logic [3:0] we,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    logic [31:0] rd0;
    req_addr  = a;
    req_we    = we;
    req_wdata = wd;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    lat = n + 1;
    rd0 = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, "_hold_rdata"}, rsp_rdata, rd0);
      check({tag, "_hold_reqrdy"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    rd = rsp_rdata;
    er = rsp_error;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_done"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          acc[3];
    int          rspc[3];
    int          na;
    int          nr;
    logic        a_hs;

    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_we = '0; req_wdata = '0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_addr = '0; z_req_we = '0; z_req_wdata = '0; z_rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_error", {31'd0, rsp_error}, 32'd0);
    check("rst_z_valid", {31'd0, z_rsp_valid}, 32'd0);
    check("rst_z_ready", {31'd0, z_req_ready}, 32'd1);

    // Full-word store then load.
    txn("st_full", 32'h10, 4'hF, 32'hDEADBEEF, 0, rd, er, lat);
    check("st_full_rdata", rd, 32'hDEADBEEF);
    check("st_full_err", {31'd0, er}, 32'd0);
    check("st_full_lat", lat, 32'd3);
    txn("ld_full", 32'h10, 4'h0, 32'h0, 0, rd, er, lat);
    check("ld_full_rdata", rd, 32'hDEADBEEF);
    check("ld_full_err", {31'd0, er}, 32'd0);
    check("ld_full_lat", lat, 32'd3);

    // Single-lane merge into an existing word.
    txn("pre_20", 32'h20, 4'hF, 32'h11223344, 0, rd, er, lat);
    txn("merge", 32'h20, 4'b0100, 32'h00AA0000, 0, rd, er, lat);
    check("merge_rdata", rd, 32'h11AA3344);
    txn("merge_ld", 32'h20, 4'h0, 32'h0, 0, rd, er, lat);
    check("merge_ld_rdata", rd, 32'h11AA3344);

    // Backpressured two-lane store.
    txn("pre_14", 32'h14, 4'hF, 32'hA5A5A5A5, 0, rd, er, lat);
    txn("bp", 32'h14, 4'b0011, 32'h00005678, 5, rd, er, lat);
    check("bp_rdata", rd, 32'hA5A55678);
    txn("bp_ld", 32'h14, 4'h0, 32'h0, 0, rd, er, lat);
    check("bp_ld_rdata", rd, 32'hA5A55678);

    // Out of range: index 1024 would alias word 0 if truncated.
    txn("pre_0", 32'h0, 4'hF, 32'h0BADF00D, 0, rd, er, lat);
    txn("oor", 32'h1000, 4'hF, 32'hFFFFFFFF, 0, rd, er, lat);
    check("oor_err", {31'd0, er}, 32'd1);
    check("oor_rdata", rd, 32'd0);
    txn("oor_ld0", 32'h0, 4'h0, 32'h0, 0, rd, er, lat);
    check("oor_ld0_rdata", rd, 32'h0BADF00D);
    check("oor_ld0_err", {31'd0, er}, 32'd0);
    txn("oor_top", 32'hFFFFFFFC, 4'h0, 32'h0, 0, rd, er, lat);
    check("oor_top_err", {31'd0, er}, 32'd1);
    check("oor_top_rdata", rd, 32'd0);
    txn("last_st", 32'h0FFC, 4'hF, 32'h12345678, 0, rd, er, lat);
    check("last_st_err", {31'd0, er}, 32'd0);
    txn("last_ld", 32'h0FFC, 4'h0, 32'h0, 0, rd, er, lat);
    check("last_ld_rdata", rd, 32'h12345678);

    // Reset in the middle of WAIT discards the captured store.
    txn("pre_c", 32'hC, 4'hF, 32'h33333333, 0, rd, er, lat);
    req_addr  = 32'hC;
    req_we    = 4'hF;
    req_wdata = 32'hFFFFFFFF;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("rstw_in_wait", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rstw_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstw_ready", {31'd0, req_ready}, 32'd1);
    tick();
    tick();
    tick();
    check("rstw_valid_later", {31'd0, rsp_valid}, 32'd0);
    txn("rstw_ld", 32'hC, 4'h0, 32'h0, 0, rd, er, lat);
    check("rstw_ld_rdata", rd, 32'h33333333);

    // Zero wait states, request held valid for three back-to-back stores.
    z_req_addr  = 32'h40;
    z_req_we    = 4'hF;
    z_req_wdata = 32'hCAFEF00D;
    z_rsp_ready = 1'b1;
    z_req_valid = 1'b1;
    na = 0;
    nr = 0;
    for (int c = 0; c < 12; c++) begin
      a_hs = z_req_valid && z_req_ready;
      if (z_rsp_valid && z_rsp_ready) begin
        check("b2b_rdata", z_rsp_rdata, 32'hCAFEF00D);
        if (nr < 3) rspc[nr] = c;
        nr++;
      end
      tick();
      if (a_hs) begin
        if (na < 3) acc[na] = c;
        na++;
        if (na == 3) z_req_valid = 1'b0;
      end
    end
    check("b2b_n_acc", na, 32'd3);
    check("b2b_n_rsp", nr, 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < na) check("b2b_acc_cycle", acc[i], 32'(3 * i));
      if (i < nr) check("b2b_rsp_cycle", rspc[i], 32'(3 * i + 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
